// File: rtl/alu_pkg.sv
// Shared ALU definitions for the pipelined carry-lookahead adder/subtractor.
//   GROUP_W             : width of one carry-lookahead group (4 bits)
//   FLAG_N/Z/V/C        : bit positions inside the 4-bit {N,Z,V,C} flag vector
//   flags_t             : the flag vector type handed to the PSR update logic
package alu_pkg;

  localparam int GROUP_W = 4;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// Ready/valid operand and result bus for cla_addsub_pipe.
//   master : producer/consumer side (drives operands, in_valid, out_ready)
//   slave  : the adder itself (drives in_ready, out_valid, sum, flags)
// Signals: in_valid/in_ready, a, b, cin, sub (operand beat);
//          out_valid/out_ready, sum, flags {N,Z,V,C} (result beat).
interface cla_addsub_pipe_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  flags_t           flags;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, flags
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, flags
  );

endinterface

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group.
//   a_i, b_i : operand nibbles
//   ci_i     : carry into bit 0
//   s_o      : sum nibble
//   co_o     : carry out of bit 3
//   c3_o     : carry into bit 3 (needed for the overflow flag of the MSB group)
module cla_group4
  import alu_pkg::*;
(
  input  logic [GROUP_W-1:0] a_i,
  input  logic [GROUP_W-1:0] b_i,
  input  logic               ci_i,
  output logic [GROUP_W-1:0] s_o,
  output logic               co_o,
  output logic               c3_o
);

  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] p;
  logic [GROUP_W:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Fully flattened lookahead: every carry depends only on g, p and ci.
  assign c[0] = ci_i;
  assign c[1] = g[0] | (p[0] & ci_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci_i);

  assign s_o  = p ^ c[GROUP_W-1:0];
  assign co_o = c[GROUP_W];
  assign c3_o = c[GROUP_W-1];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with ready/valid handshake.
// Each stage adds STAGE_GROUPS 4-bit lookahead groups; the stage carry is the
// only carry that is registered. Unused operand bits shift down the pipe and
// finished sum slices shift in from the top, so after LAT stages the sum is
// aligned. Pipeline depth LAT = WIDTH / (4*STAGE_GROUPS).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cla_addsub_pipe_if.slave (operands in, result + {N,Z,V,C} out)
// Build option: define CLA_PIPE_SAT_EN to saturate the sum on signed overflow;
// without it the result wraps (two's complement).
module cla_addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int STAGE_GROUPS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  cla_addsub_pipe_if.slave    bus
);

  localparam int SW  = GROUP_W * STAGE_GROUPS;
  localparam int LAT = WIDTH / SW;

  // Stage registers (index k = output of stage k)
  logic [LAT-1:0]   valid_q;
  logic             carry_q [LAT];
  logic             zero_q  [LAT];
  logic [WIDTH-1:0] opa_q   [LAT];
  logic [WIDTH-1:0] opb_q   [LAT];
  logic [WIDTH-1:0] sum_q   [LAT];
  flags_t           flags_q;

  // Per-stage combinational signals
  logic [WIDTH-1:0] opa_in [LAT];
  logic [WIDTH-1:0] opb_in [LAT];
  logic [WIDTH-1:0] sum_in [LAT];
  logic             c_in   [LAT];
  logic             zero_in[LAT];
  logic [WIDTH-1:0] opa_d  [LAT];
  logic [WIDTH-1:0] opb_d  [LAT];
  logic [WIDTH-1:0] sum_d  [LAT];
  logic             zero_d [LAT];
  logic             co_d   [LAT];
  logic [SW-1:0]    slice_s[LAT];
  logic             gc     [LAT][STAGE_GROUPS+1];
  logic             gc3    [LAT][STAGE_GROUPS];

  logic             advance;
  logic [WIDTH-1:0] sum_fin;
  logic             n_raw;
  logic             v_flag;
  logic             z_flag;
  flags_t           flags_d;

  // Global enable: the whole pipe moves unless a result is waiting unconsumed.
  assign advance       = ~valid_q[LAT-1] | bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = valid_q[LAT-1];
  assign bus.sum       = sum_q[LAT-1];
  assign bus.flags     = flags_q;

  for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      // Subtraction as A + ~B + ~cin, so cin acts as a borrow-in.
      assign opa_in[gi]  = bus.a;
      assign opb_in[gi]  = bus.sub ? ~bus.b : bus.b;
      assign c_in[gi]    = bus.sub ? ~bus.cin : bus.cin;
      assign zero_in[gi] = 1'b1;
      assign sum_in[gi]  = '0;
    end else begin : g_rest
      assign opa_in[gi]  = opa_q[gi-1];
      assign opb_in[gi]  = opb_q[gi-1];
      assign c_in[gi]    = carry_q[gi-1];
      assign zero_in[gi] = zero_q[gi-1];
      assign sum_in[gi]  = sum_q[gi-1];
    end

    assign gc[gi][0] = c_in[gi];

    for (genvar gj = 0; gj < STAGE_GROUPS; gj++) begin : g_group
      cla_group4 u_grp (
        .a_i  (opa_in[gi][gj*GROUP_W +: GROUP_W]),
        .b_i  (opb_in[gi][gj*GROUP_W +: GROUP_W]),
        .ci_i (gc[gi][gj]),
        .s_o  (slice_s[gi][gj*GROUP_W +: GROUP_W]),
        .co_o (gc[gi][gj+1]),
        .c3_o (gc3[gi][gj])
      );
    end

    assign co_d[gi]   = gc[gi][STAGE_GROUPS];
    assign zero_d[gi] = zero_in[gi] & ~|slice_s[gi];
    // Consumed low slice drops off; new sum slice enters at the top.
    assign opa_d[gi]  = opa_in[gi] >> SW;
    assign opb_d[gi]  = opb_in[gi] >> SW;
    assign sum_d[gi]  = (sum_in[gi] >> SW) | (WIDTH'(slice_s[gi]) << (WIDTH - SW));
  end

  // Final stage: overflow from the carry into vs. out of the MSB.
  always_comb begin
    n_raw   = sum_d[LAT-1][WIDTH-1];
    v_flag  = gc3[LAT-1][STAGE_GROUPS-1] ^ co_d[LAT-1];
    sum_fin = sum_d[LAT-1];
    z_flag  = zero_d[LAT-1];
`ifdef CLA_PIPE_SAT_EN
    // A wrapped-negative sign means positive overflow and vice versa;
    // saturated values are never zero.
    if (v_flag) begin
      sum_fin = {~n_raw, {(WIDTH-1){n_raw}}};
      z_flag  = 1'b0;
    end
`endif
    flags_d         = '0;
    flags_d[FLAG_N] = sum_fin[WIDTH-1];
    flags_d[FLAG_Z] = z_flag;
    flags_d[FLAG_V] = v_flag;
    flags_d[FLAG_C] = co_d[LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      flags_q <= '0;
      for (int k = 0; k < LAT; k++) begin
        carry_q[k] <= 1'b0;
        zero_q[k]  <= 1'b0;
        opa_q[k]   <= '0;
        opb_q[k]   <= '0;
        sum_q[k]   <= '0;
      end
    end else if (advance) begin
      valid_q[0] <= bus.in_valid;
      for (int k = 1; k < LAT; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
      for (int k = 0; k < LAT; k++) begin
        carry_q[k] <= co_d[k];
        zero_q[k]  <= zero_d[k];
        opa_q[k]   <= opa_d[k];
        opb_q[k]   <= opb_d[k];
        sum_q[k]   <= (k == LAT-1) ? sum_fin : sum_d[k];
      end
      flags_q <= flags_d;
    end
  end

endmodule
